// File: rtl/led_pattern_gen.sv
// LED pattern engine: a prescaled step tick drives one of four patterns
// (binary count, Gray count, bouncing scanner, PWM breathing) onto WIDTH LEDs.
// The LED register reloads every clock from the pre-edge state, so it trails
// any state change by one clock.
module led_pattern_gen #(
  parameter int WIDTH    = 8,
  parameter int DIV      = 6000000,
  parameter int PWM_BITS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] led_o,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PRE_W-1:0]    PRE_MAX    = PRE_W'(DIV - 1);
  localparam logic [POS_W-1:0]    POS_MAX    = POS_W'(WIDTH - 1);
  localparam logic [PWM_BITS-1:0] BRIGHT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_BIN     = 2'd0,
    MODE_GRAY    = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0]    count_q, count_d;
  mode_e               mode_q, mode_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  dir_e                pos_dir_q, pos_dir_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  dir_e                bright_dir_q, bright_dir_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [WIDTH-1:0]    led_q, led_d;

  logic                tick;
  mode_e               mode_in;
  logic [WIDTH-1:0]    onehot;
  logic [WIDTH-1:0]    gray;
  logic                pwm_on;

  // Step tick is the last prescaler count of an enabled cycle; forced low in reset.
  assign tick    = en_i & rst_ni & (pre_q == PRE_MAX);
  assign mode_in = mode_e'(mode_i);

  // Scanner one-hot decode, one comparator per LED.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
    assign onehot[gi] = (pos_q == POS_W'(gi));
  end

  assign gray   = count_q ^ (count_q >> 1);
  assign pwm_on = (pwm_q < bright_q);

  // Next-state for prescaler, PWM counter, mode capture and pattern stepping.
  always_comb begin
    pre_d        = pre_q;
    pwm_d        = pwm_q;
    count_d      = count_q;
    mode_d       = mode_q;
    pos_d        = pos_q;
    pos_dir_d    = pos_dir_q;
    bright_d     = bright_q;
    bright_dir_d = bright_dir_q;

    if (en_i) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
      pwm_d = pwm_q + PWM_BITS'(1);
    end

    if (tick) begin
      if (mode_in != mode_q) begin
        // A new mode restarts its pattern from the beginning instead of advancing.
        mode_d       = mode_in;
        count_d      = '0;
        pos_d        = '0;
        bright_d     = '0;
        pos_dir_d    = DIR_UP;
        bright_dir_d = DIR_UP;
      end else begin
        case (mode_q)
          MODE_BIN, MODE_GRAY: begin
            count_d = count_q + WIDTH'(1);
          end
          MODE_SCAN: begin
            // A single LED has nowhere to move, so pos stays at 0.
            if (WIDTH > 1) begin
              if (pos_dir_q == DIR_UP) begin
                if (pos_q == POS_MAX) begin
                  pos_dir_d = DIR_DOWN;
                  pos_d     = pos_q - POS_W'(1);
                end else begin
                  pos_d     = pos_q + POS_W'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  pos_dir_d = DIR_UP;
                  pos_d     = POS_W'(1);
                end else begin
                  pos_d     = pos_q - POS_W'(1);
                end
              end
            end
          end
          MODE_BREATHE: begin
            if (bright_dir_q == DIR_UP) begin
              if (bright_q == BRIGHT_MAX) begin
                bright_dir_d = DIR_DOWN;
                bright_d     = bright_q - PWM_BITS'(1);
              end else begin
                bright_d     = bright_q + PWM_BITS'(1);
              end
            end else begin
              if (bright_q == '0) begin
                bright_dir_d = DIR_UP;
                bright_d     = PWM_BITS'(1);
              end else begin
                bright_d     = bright_q - PWM_BITS'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // LED image of the current state, selected by the captured mode.
  always_comb begin
    led_d = count_q;
    case (mode_q)
      MODE_BIN:     led_d = count_q;
      MODE_GRAY:    led_d = gray;
      MODE_SCAN:    led_d = onehot;
      MODE_BREATHE: led_d = {WIDTH{pwm_on}};
      default:      led_d = count_q;
    endcase
  end

  // State registers; reset clears everything immediately, without a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q        <= '0;
      pwm_q        <= '0;
      count_q      <= '0;
      mode_q       <= MODE_BIN;
      pos_q        <= '0;
      pos_dir_q    <= DIR_UP;
      bright_q     <= '0;
      bright_dir_q <= DIR_UP;
      led_q        <= '0;
    end else begin
      pre_q        <= pre_d;
      pwm_q        <= pwm_d;
      count_q      <= count_d;
      mode_q       <= mode_d;
      pos_q        <= pos_d;
      pos_dir_q    <= pos_dir_d;
      bright_q     <= bright_d;
      bright_dir_q <= bright_dir_d;
      led_q        <= led_d;
    end
  end

  assign led_o   = led_q;
  assign count_o = count_q;
  assign tick_o  = tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen with WIDTH=4, DIV=3, PWM_BITS=2, plus a WIDTH=1
// instance sharing the same stimulus. Expected step results are queued as each
// step is requested and popped when the tick that produces them has happened.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       en_i;
  logic [1:0] mode_i;
  logic [3:0] led_o;
  logic [3:0] count_o;
  logic       tick_o;
  logic [0:0] led1_o;
  logic [0:0] count1_o;
  logic       tick1_o;

  led_pattern_gen #(.WIDTH(4), .DIV(3), .PWM_BITS(2)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (en_i),
    .mode_i  (mode_i),
    .led_o   (led_o),
    .count_o (count_o),
    .tick_o  (tick_o)
  );

  led_pattern_gen #(.WIDTH(1), .DIV(3), .PWM_BITS(2)) dut1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (en_i),
    .mode_i  (mode_i),
    .led_o   (led1_o),
    .count_o (count1_o),
    .tick_o  (tick1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int cnt;
    int led;
    int bright;
    bit adj;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t exp_q[$];
  vec_t vecs[$];
  int   prev_mode, prev_cnt, prev_led, prev_bright;
  int   pc;
  int   gray_tab[16]  = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  int   scan_tab[8]   = '{1, 2, 4, 8, 4, 2, 1, 2};
  int   bright_tab[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

  // Independent count of enabled clocks since reset: the PWM phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 0;
    else if (en_i) pc <= pc + 1;
  end

  function automatic vec_t mk(int m, int c, int l, int b, bit a);
    vec_t v;
    v.mode = m; v.cnt = c; v.led = l; v.bright = b; v.adj = a;
    return v;
  endfunction

  function automatic int led3(int p, int b);
    return ((p & 3) < b) ? 15 : 0;
  endfunction

  // LED value produced from the state left by the previous step.
  function automatic int exp_old_led();
    return (prev_mode == 3) ? led3(pc - 1, prev_bright) : prev_led;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_tick(output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (tick_o === 1'b1) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL tick_timeout: got no tick in %0d clocks, expected one (t=%0t)", cyc, $time);
  endtask

  // Called at the negedge where tick is visible; checks the two clocks that follow.
  task automatic after_tick();
    vec_t       e;
    int         new_led;
    logic [3:0] pl;
    e = exp_q.pop_front();
    @(negedge clk);
    chk("count_step", count_o, e.cnt);
    chk("led_lag", led_o, exp_old_led());
    @(negedge clk);
    new_led = (e.mode == 3) ? led3(pc - 1, e.bright) : e.led;
    chk("count", count_o, e.cnt);
    chk("led", led_o, new_led);
    if (e.mode == 2) chk("led_w1", led1_o, 1);
    if (e.adj) begin
      pl = prev_led[3:0];
      chk("gray_adj", $countones(led_o ^ pl), 1);
    end
    $display("step mode=%0d count=%0d led=%b bright=%0d", e.mode, count_o, led_o, e.bright);
    prev_mode   = e.mode;
    prev_cnt    = e.cnt;
    prev_led    = new_led;
    prev_bright = e.bright;
  endtask

  task automatic run_row(input vec_t v);
    int cyc;
    exp_q.push_back(v);
    mode_i = 2'(v.mode);
    wait_tick(cyc);
    chk("tick_period", cyc, 1);
    chk("hold_count", count_o, prev_cnt);
    chk("hold_led", led_o, exp_old_led());
    after_tick();
  endtask

  task automatic release_and_first();
    int cyc;
    prev_mode = 0; prev_cnt = 0; prev_led = 0; prev_bright = 0;
    mode_i = 2'd0;
    rst_n  = 1'b1;
    exp_q.push_back(mk(0, 1, 1, 0, 0));
    wait_tick(cyc);
    chk("first_tick_latency", cyc, 2);
    chk("first_tick_count", count_o, 0);
    after_tick();
  endtask

  initial begin
    int cyc;
    // Vector table for the main sweep.
    for (int k = 2; k <= 17; k++) vecs.push_back(mk(0, k % 16, k % 16, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0));
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(1, k % 16, gray_tab[k % 16], 0, 1));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(2, 0, scan_tab[i], 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(3, 0, 0, bright_tab[i], 0));
    vecs.push_back(mk(0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0));

    rst_n  = 1'b0;
    en_i   = 1'b0;
    mode_i = 2'd0;
    #1;
    chk("reset_led", led_o, 0);
    chk("reset_count", count_o, 0);
    chk("reset_tick", tick_o, 0);
    en_i = 1'b1;
    @(negedge clk);
    chk("reset_tick_en", tick_o, 0);
    chk("reset_led_w1", led1_o, 0);
    @(negedge clk);

    // Run to count 9, then pull reset while tick is high.
    release_and_first();
    for (int k = 2; k <= 9; k++) run_row(mk(0, k, k, 0, 0));
    wait_tick(cyc);
    chk("pre_reset_count", count_o, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", led_o, 0);
    chk("async_rst_count", count_o, 0);
    chk("async_rst_tick", tick_o, 0);
    @(negedge clk);
    @(negedge clk);
    release_and_first();

    for (int i = 0; i < vecs.size(); i++) run_row(vecs[i]);

    // Enable low mid-interval freezes everything; the interval then completes.
    en_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("en_low_tick", tick_o, 0);
      chk("en_low_led", led_o, 1);
      chk("en_low_count", count_o, 1);
    end
    en_i = 1'b1;
    run_row(mk(0, 2, 2, 0, 0));

    // Mode glitch 1->2->1 between ticks must not restart the Gray count.
    run_row(mk(1, 0, 0, 0, 0));
    run_row(mk(1, 1, 1, 0, 0));
    exp_q.push_back(mk(1, 2, 3, 0, 0));
    mode_i = 2'd2;
    @(negedge clk);
    chk("toggle_tick", tick_o, 1);
    mode_i = 2'd1;
    after_tick();

    // Mode 0 -> 2 takes effect only at the next tick, starting at pos 0.
    run_row(mk(0, 0, 0, 0, 0));
    run_row(mk(0, 1, 1, 0, 0));
    run_row(mk(0, 2, 2, 0, 0));
    run_row(mk(2, 0, 1, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
